ram_read_arbiter: RTL
=====================

RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before a transaction is aborted.
REQ-002 Parameter ERRDATA, default 32'hDEADBEEF: data returned on an aborted transaction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 reqA  input  1  read request, port A (ALU); held high until ackA is seen.
REQ-006 addrA  input  8  read address, port A.
REQ-007 ackA  output  1  one-cycle acknowledge, port A; dataA valid in the same cycle.
REQ-008 dataA  output  32  read data, port A; holds its value until the next port-A ack.
REQ-009 reqB, addrB, ackB, dataB  in/in/out/out  1/8/1/32  same as port A, for port B (loader/debug).
REQ-010 readReq  output  1  read request to RAM.
REQ-011 ramAddress  output  8  address to RAM.
REQ-012 readAck  input  1  RAM acknowledge; ramIn is valid while readAck is high.
REQ-013 ramIn  input  32  RAM read data.
REQ-014 timeoutErr  output  1  sticky flag, set on any aborted transaction.
REQ-015 debug  output  32  {state[1:0], lastGrant, 5'b0, waitCnt[7:0], ramAddress[7:0], 8'b0}.

Function
REQ-016 FSM states: IDLE, WAIT, DONE; all outputs registered.
REQ-017 IDLE: if (reqA|reqB) and !readAck, pick a winner, latch its address to ramAddress, set readReq=1, clear waitCnt, go to WAIT; otherwise stay in IDLE with readReq=0.
REQ-018 Winner: the single requester if only one is high; if both are high, the port that was not lastGrant.
REQ-019 WAIT, readAck=1: readReq<=0, data<=ramIn for the granted port, ack<=1 for one cycle, lastGrant<=granted port, go to DONE.
REQ-020 WAIT, readAck=0: waitCnt<=waitCnt+1; when waitCnt==TIMEOUT: readReq<=0, data<=ERRDATA, ack pulse, timeoutErr<=1, lastGrant updated, go to DONE.
REQ-021 DONE: lasts exactly one cycle, ignores all req inputs (a requester's stale req is still high here), then goes to IDLE.
REQ-022 Minimum latency: req sampled at edge n, readReq high after n, readAck sampled at n+k, ack high after n+k; earliest regrant at n+k+2.
REQ-023 A req dropping during WAIT does not cancel the transaction; the ack is still issued.
REQ-024 ackA and ackB are never high together; at most one RAM transaction is outstanding.
REQ-025 The ungranted port's ack stays 0 and its data is unchanged.
REQ-026 Changes to addrA/addrB after the grant do not affect ramAddress.
REQ-027 waitCnt saturates and does not wrap; it is 8 bits wide and TIMEOUT is at most 255.
REQ-028 timeoutErr clears only on reset.

Reset
REQ-029 While reset=0: state=IDLE, readReq=0, ramAddress=0, ackA=ackB=0, dataA=dataB=0, lastGrant=B (so A wins the first tie), waitCnt=0, timeoutErr=0, debug=0.
REQ-030 Reset asserted mid-transaction aborts it with no ack; after release, the FSM starts in IDLE and re-arbitrates.

Structure
REQ-031 The shared package holds: FSM state encoding, port index constants (PORT_A=0, PORT_B=1), TIMEOUT default, ERRDATA default.
REQ-032 One sub-module is natural: arb_rr_pick, a combinational 2-way round-robin picker (inputs reqA, reqB, lastGrant; outputs grant valid and grant index); all sequencing stays in ram_read_arbiter.

Verification
REQ-033 Only reqA, addrA=8'h10; RAM acks 2 cycles after readReq with 32'h12345678 -> ramAddress=8'h10, one-cycle ackA, dataA=32'h12345678, ackB never high.
REQ-034 reqA and reqB raised in the same cycle just after reset (addrA=8'h04, addrB=8'h08) -> A is served first, then B; ramAddress sequence 04, 08; exactly one ack each.
REQ-035 reqA and reqB held continuously, each re-raised 1 cycle after its ack -> grants strictly alternate A,B,A,B over 8 transactions.
REQ-036 reqB, RAM never acks -> after TIMEOUT+1 WAIT cycles: ackB pulse, dataB=32'hDEADBEEF, timeoutErr=1; a following reqA completes normally and timeoutErr stays 1.
REQ-037 reset driven low during WAIT of a port-A read -> readReq=0 and no ackA; after release, a pending reqB is granted next.
REQ-038 readAck held high by RAM in IDLE while reqA=1 -> no grant until readAck=0, then a normal transaction.

Source files
------------

// File: rtl/ram_read_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram_read_arbiter_pkg
// Description : Shared types and constants for the two-port RAM read arbiter:
//               FSM state encoding, port indices and parameter defaults.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
package ram_read_arbiter_pkg;

  // Arbiter sequencing states; IDLE must encode as zero so debug reads 0 in reset
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Port indices as stored in lastGrant / granted-port registers
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Parameter defaults for the top level
  localparam int          TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ERRDATA_DEFAULT = 32'hDEADBEEF;

endpackage : ram_read_arbiter_pkg
`default_nettype wire

// File: rtl/ram_read_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram_read_arbiter_if
// Description : Bundles both requester ports and the RAM read port of the
//               arbiter. The slave modport is the arbiter's view, the master
//               modport is the surrounding system (requesters plus RAM).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
interface ram_read_arbiter_if;

  // Port A (ALU)
  logic        reqA;
  logic [7:0]  addrA;
  logic        ackA;
  logic [31:0] dataA;

  // Port B (loader / debug)
  logic        reqB;
  logic [7:0]  addrB;
  logic        ackB;
  logic [31:0] dataB;

  // RAM read port
  logic        readReq;
  logic [7:0]  ramAddress;
  logic        readAck;
  logic [31:0] ramIn;

  modport slave (
    input  reqA, addrA, reqB, addrB, readAck, ramIn,
    output ackA, dataA, ackB, dataB, readReq, ramAddress
  );

  modport master (
    output reqA, addrA, reqB, addrB, readAck, ramIn,
    input  ackA, dataA, ackB, dataB, readReq, ramAddress
  );

endinterface : ram_read_arbiter_if
`default_nettype wire

// File: rtl/ram_read_arbiter_arb_rr_pick.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : arb_rr_pick
// Description : Combinational two-way round-robin picker. A lone requester
//               wins; on a tie the port that was not granted last wins.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module arb_rr_pick
  import ram_read_arbiter_pkg::*;
(
  input  wire logic req_a,
  input  wire logic req_b,
  input  wire logic last_grant,
  output logic      gnt_valid,
  output logic      gnt_idx
);

  // Select the winning port from the current requests and grant history
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_idx   = PORT_A;
    if (req_a && req_b) begin
      gnt_idx = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      gnt_idx = PORT_B;
    end
  end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/ram_read_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram_read_arbiter
// Description : Arbitrates read requests from two ports onto one RAM read
//               port. One transaction in flight at a time; a transaction the
//               RAM does not answer within TIMEOUT+1 wait cycles is aborted
//               with ERRDATA and a sticky timeoutErr flag.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module ram_read_arbiter
  import ram_read_arbiter_pkg::*;
#(
  parameter int          TIMEOUT = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERRDATA = ERRDATA_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         reset,
  ram_read_arbiter_if.slave bus,
  output logic              timeoutErr,
  output logic [31:0]       debug
);

  // waitCnt is 8 bits wide, so the abort threshold is taken modulo 256
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q,       state_d;
  logic        read_req_q,    read_req_d;
  logic [7:0]  ram_address_q, ram_address_d;
  logic        ack_a_q,       ack_a_d;
  logic        ack_b_q,       ack_b_d;
  logic [31:0] data_a_q,      data_a_d;
  logic [31:0] data_b_q,      data_b_d;
  logic        last_grant_q,  last_grant_d;
  logic        granted_q,     granted_d;
  logic [7:0]  wait_cnt_q,    wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] debug_q,       debug_d;

  logic        pick_valid;
  logic        pick_idx;

  arb_rr_pick u_pick (
    .req_a      (bus.reqA),
    .req_b      (bus.reqB),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  // Next-state and next-output logic of the IDLE/WAIT/DONE sequencer
  always_comb begin
    state_d       = state_q;
    read_req_d    = read_req_q;
    ram_address_d = ram_address_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    data_a_d      = data_a_q;
    data_b_d      = data_b_q;
    last_grant_d  = last_grant_q;
    granted_d     = granted_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        read_req_d = 1'b0;
        // A RAM still asserting readAck from earlier activity blocks new grants
        if (pick_valid && !bus.readAck) begin
          granted_d     = pick_idx;
          ram_address_d = (pick_idx == PORT_A) ? bus.addrA : bus.addrB;
          read_req_d    = 1'b1;
          wait_cnt_d    = 8'd0;
          state_d       = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.readAck || (wait_cnt_q == TIMEOUT_CNT)) begin
          // Completion and abort share the same hand-back; only data differs
          read_req_d   = 1'b0;
          last_grant_d = granted_q;
          state_d      = ST_DONE;
          if (granted_q == PORT_A) begin
            ack_a_d  = 1'b1;
            data_a_d = bus.readAck ? bus.ramIn : ERRDATA;
          end else begin
            ack_b_d  = 1'b1;
            data_b_d = bus.readAck ? bus.ramIn : ERRDATA;
          end
          if (!bus.readAck) begin
            timeout_err_d = 1'b1;
          end
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // Requesters still show a stale req here; it is deliberately ignored
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        read_req_d = 1'b0;
      end
    endcase

    debug_d = {state_d, last_grant_d, 5'b0, wait_cnt_d, ram_address_d, 8'b0};
  end

  // State and output registers; lastGrant resets to B so A wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      read_req_q    <= 1'b0;
      ram_address_q <= 8'd0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      data_a_q      <= 32'd0;
      data_b_q      <= 32'd0;
      last_grant_q  <= PORT_B;
      granted_q     <= PORT_A;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
      debug_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      read_req_q    <= read_req_d;
      ram_address_q <= ram_address_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      last_grant_q  <= last_grant_d;
      granted_q     <= granted_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      debug_q       <= debug_d;
    end
  end

  assign bus.readReq    = read_req_q;
  assign bus.ramAddress = ram_address_q;
  assign bus.ackA       = ack_a_q;
  assign bus.ackB       = ack_b_q;
  assign bus.dataA      = data_a_q;
  assign bus.dataB      = data_b_q;
  assign timeoutErr     = timeout_err_q;
  assign debug          = debug_q;

endmodule : ram_read_arbiter
`default_nettype wire
